// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter that shares the L2 cache port between the icache and dcache miss paths.
// Each grant is held until l2_resp and is followed by a one-cycle release bubble; a watchdog flags stalls.
module l2_rr_arbiter #(
  parameter int s_line  = 256,
  parameter int s_addr  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [s_addr-1:0] i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_addr-1:0] d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [s_addr-1:0] l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  state_t     state;
  logic       last_gnt;   // 0 = icache served last, 1 = dcache served last
  logic [9:0] wait_cnt;
  logic       i_req;
  logic       d_req;
  logic       granted;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign granted = (state == GNT_I) || (state == GNT_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (i_req && d_req)
            state <= last_gnt ? GNT_I : GNT_D;
          else if (i_req)
            state <= GNT_I;
          else if (d_req)
            state <= GNT_D;
        end
        // A dropped request (abort) releases the port exactly like a completion.
        GNT_I: begin
          if (l2_resp || !i_req) begin
            state    <= RELEASE;
            last_gnt <= 1'b0;
          end
        end
        GNT_D: begin
          if (l2_resp || !d_req) begin
            state    <= RELEASE;
            last_gnt <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Watchdog: count stalled grant cycles, saturate at TMO; the flag is sticky.
      if (granted && !l2_resp) begin
        if (wait_cnt != TMO)
          wait_cnt <= wait_cnt + 10'd1;
        if (wait_cnt >= TMO - 10'd1)
          timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    i_rdata    = '0;
    d_resp     = 1'b0;
    d_rdata    = '0;
    case (state)
      GNT_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        i_resp     = l2_resp;
        i_rdata    = l2_rdata;
      end
      GNT_D: begin
        // Write wins when both d_read and d_write are (illegally) high.
        l2_read    = d_read & ~d_write;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
        d_rdata    = l2_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Directed self-checking bench for l2_rr_arbiter, built with TIMEOUT=8 so the watchdog is reachable.
module tb_l2_rr_arbiter;

  localparam int SL = 256;
  localparam int SA = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [SA-1:0] i_address;
  logic [SL-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [SA-1:0] d_address;
  logic [SL-1:0] d_wdata;
  logic [SL-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [SA-1:0] l2_address;
  logic [SL-1:0] l2_wdata;
  logic [SL-1:0] l2_rdata;
  logic          l2_resp;
  logic          timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  l2_rr_arbiter #(.s_line(SL), .s_addr(SA), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [SL-1:0] obs, input logic [SL-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_l2_read", SL'(l2_read), SL'(0));
    chk("rst_timeout", SL'(timeout_err), SL'(0));
  endtask

  // Starts in IDLE with requests already driven; expects the given side to be granted.
  task automatic do_xact(input string tag, input bit exp_d, input logic [SA-1:0] exp_addr,
                         input bit exp_wr, input int waits, input bit drop);
    logic [SL-1:0] data;
    data = {8{$urandom()}};
    tick();
    chk({tag, "_addr"}, SL'(l2_address), SL'(exp_addr));
    chk({tag, "_rd"}, SL'(l2_read), SL'(!exp_wr));
    chk({tag, "_wr"}, SL'(l2_write), SL'(exp_wr));
    for (int k = 0; k < waits; k++) begin
      tick();
      chk({tag, "_hold"}, SL'(l2_read | l2_write), SL'(1));
    end
    l2_resp = 1'b1;
    l2_rdata = data;
    #1;
    chk({tag, "_i_resp"}, SL'(i_resp), SL'(!exp_d));
    chk({tag, "_d_resp"}, SL'(d_resp), SL'(exp_d));
    chk({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, data);
    chk({tag, "_other_rdata"}, exp_d ? i_rdata : d_rdata, SL'(0));
    tick();
    l2_resp = 1'b0;
    if (drop) begin
      i_read = 0; d_read = 0; d_write = 0;
    end
    #1;
    chk({tag, "_release"}, SL'({l2_read, l2_write, i_resp, d_resp}), SL'(0));
    tick();
    $display("xact %s side=%s addr=%0h done", tag, exp_d ? "D" : "I", exp_addr);
  endtask

  initial begin
    // 1: single icache fill, L2 answers 3 cycles after l2_read rises
    do_reset();
    i_read = 1; i_address = 32'h0000_0040;
    #1;
    chk("t1_idle_no_comb", SL'(l2_read), SL'(0));
    do_xact("t1", 1'b0, 32'h0000_0040, 1'b0, 2, 1'b1);
    chk("t1_idle_after", SL'({l2_read, i_resp}), SL'(0));
    chk("t1_no_timeout", SL'(timeout_err), SL'(0));

    // 2: simultaneous requests held continuously alternate I,D,I,D
    do_reset();
    i_read = 1; i_address = 32'h0000_0100;
    d_read = 1; d_address = 32'h0000_0200;
    do_xact("t2a", 1'b0, 32'h0000_0100, 1'b0, 0, 1'b0);
    do_xact("t2b", 1'b1, 32'h0000_0200, 1'b0, 1, 1'b0);
    do_xact("t2c", 1'b0, 32'h0000_0100, 1'b0, 0, 1'b0);
    do_xact("t2d", 1'b1, 32'h0000_0200, 1'b0, 0, 1'b1);

    // 3: dcache writeback
    do_reset();
    d_write = 1; d_address = 32'h0000_0D80; d_wdata = {32{8'hA5}};
    tick();
    chk("t3_wdata", l2_wdata, {32{8'hA5}});
    chk("t3_i_resp_idle", SL'(i_resp), SL'(0));
    rst = 1; #1; rst = 0;  // return to IDLE for the common transaction helper
    do_xact("t3", 1'b1, 32'h0000_0D80, 1'b1, 1, 1'b1);

    // 4: asynchronous reset in the middle of a dcache grant
    do_reset();
    d_write = 1; d_address = 32'h0000_0300; d_wdata = {32{8'h3C}};
    tick();
    chk("t4_pre_wr", SL'(l2_write), SL'(1));
    rst = 1'b1;
    #1;
    chk("t4_async_drop", SL'({l2_write, l2_read}), SL'(0));
    d_write = 0;
    i_read = 1; i_address = 32'h0000_0400;
    d_read = 1; d_address = 32'h0000_0500;
    tick();
    rst = 1'b0;
    #1;
    do_xact("t4", 1'b0, 32'h0000_0400, 1'b0, 0, 1'b1);

    // 5: watchdog with TIMEOUT=8
    do_reset();
    i_read = 1; i_address = 32'h0000_0600;
    tick();
    chk("t5_grant", SL'(l2_read), SL'(1));
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("t5_tmo_k%0d", k), SL'(timeout_err), SL'(k >= 8));
    end
    l2_resp = 1; l2_rdata = {16{16'hBEEF}};
    #1;
    chk("t5_late_resp", SL'(i_resp), SL'(1));
    chk("t5_late_rdata", i_rdata, {16{16'hBEEF}});
    tick();
    l2_resp = 0; i_read = 0;
    #1;
    tick();
    chk("t5_sticky", SL'(timeout_err), SL'(1));

    // 6: icache aborts mid-grant, pending dcache read is served next
    do_reset();
    i_read = 1; i_address = 32'h0000_0700;
    d_read = 1; d_address = 32'h0000_0800;
    tick();
    chk("t6_grant_i", SL'(l2_address), SL'(32'h0000_0700));
    tick();
    tick();
    i_read = 0;
    #1;
    chk("t6_abort_resp", SL'(i_resp), SL'(0));
    tick();
    chk("t6_release", SL'({l2_read, l2_write, i_resp, d_resp}), SL'(0));
    tick();
    chk("t6_idle", SL'(l2_read), SL'(0));
    do_xact("t6", 1'b1, 32'h0000_0800, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog bench time limit reached");
    $fatal(1, "time limit");
  end

endmodule
